// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative digit multiplier.
// Digit width, FSM states and the conditional magnitude function.
package mult_pkg;

    localparam int DIGIT_W   = 2;
    localparam int ABS_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    // Caller sign- or zero-extends the operand to ABS_MAX_W bits first.
    function automatic logic [ABS_MAX_W-1:0] abs_w(
        input logic [ABS_MAX_W-1:0] v,
        input logic                 sgn
    );
        if (sgn && v[ABS_MAX_W-1]) begin
            return -v;
        end
        return v;
    endfunction

endpackage

// File: rtl/mult_iter_digit_cell.sv
// Combinational 2x2-bit unsigned multiplier cell.
// Gate-level form so a generated cell netlist can replace it directly.
module mult2x2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic a0b0;
    logic a1b0;
    logic a0b1;
    logic a1b1;
    logic c1;

    assign a0b0 = a[0] & b[0];
    assign a1b0 = a[1] & b[0];
    assign a0b1 = a[0] & b[1];
    assign a1b1 = a[1] & b[1];
    assign c1   = a1b0 & a0b1;

    assign p[0] = a0b0;
    assign p[1] = a1b0 ^ a0b1;
    assign p[2] = a1b1 ^ c1;
    assign p[3] = a1b1 & c1;

endmodule

// File: rtl/mult_iter_digit.sv
// Iterative WIDTH x WIDTH multiplier, one 2-bit B digit per cycle.
// Magnitudes are multiplied unsigned; the sign is applied at the end.
module mult_iter_digit
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    mult_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;

    logic [ABS_MAX_W-1:0] a_ext;
    logic [ABS_MAX_W-1:0] b_ext;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [DIGIT_W-1:0]   b_dig;
    logic [2*DIGIT_W-1:0] cell_p [DIGITS];
    logic [PW-1:0]        row;
    logic [PW-1:0]        acc_next;

    // Operand magnitudes for capture in IDLE.
    always_comb begin
        a_ext = {{(ABS_MAX_W-WIDTH){is_signed & A[WIDTH-1]}}, A};
        b_ext = {{(ABS_MAX_W-WIDTH){is_signed & B[WIDTH-1]}}, B};
        a_mag = WIDTH'(abs_w(a_ext, is_signed));
        b_mag = WIDTH'(abs_w(b_ext, is_signed));
    end

    assign b_dig = DIGIT_W'(b_q >> {cnt_q, 1'b0});

    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
        mult2x2_cell u_cell (
            .a (a_q[i*DIGIT_W +: DIGIT_W]),
            .b (b_dig),
            .p (cell_p[i])
        );
    end

    // Sum the cell products into one row and add it at the digit weight.
    always_comb begin
        row = '0;
        for (int i = 0; i < DIGITS; i++) begin
            row = row + (PW'(cell_p[i]) << (i * DIGIT_W));
        end
        acc_next = acc_q + (row << {cnt_q, 1'b0});
    end

    // Next-state and datapath updates for IDLE -> RUN -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_mag;
                    b_d     = b_mag;
                    neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = neg_q ? -acc_next : acc_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE) & ~rst;
    assign P         = p_q;

endmodule
